// File: rtl/keypad_ctrl.sv
// Keypad sequencing controller: debounces a 4x4 key array, rejects chords, strobes one
// key code per press into the key buffer, tracks buffer fill and turns the clear level into a pulse.
module keypad_ctrl #(
   parameter int DEBOUNCE = 4,
   parameter int CW       = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] keys,
   input  logic        clear_in,
   output logic        key_valid,
   output logic [3:0]  key_val,
   output logic        clear_out,
   output logic [3:0]  ndigits,
   output logic        full,
   output logic        overflow,
   output logic        multi
);

   // state      | meaning
   // S_IDLE     | no key pressed, waiting for a single key
   // S_DEBOUNCE | single key seen, waiting for it to stay stable
   // S_HELD     | key accepted (or dropped), waiting for full release
   // S_RELEASE  | all keys released, waiting for release to stay stable
   typedef enum logic [1:0] {
      S_IDLE,
      S_DEBOUNCE,
      S_HELD,
      S_RELEASE
   } state_t;

   localparam logic [CW-1:0] DB_LIMIT = CW'(DEBOUNCE);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [15:0]   cap_keys;
   logic [3:0]    cap_code;
   logic          clear_prev;

   logic [4:0]    key_count;
   logic [3:0]    key_code;
   logic          clear_edge;
   logic          accept;

   always_comb begin
      key_count = 5'd0;
      key_code  = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (keys[i]) begin
            key_count = key_count + 5'd1;
            key_code  = 4'(i);
         end
      end
   end

   assign clear_edge = clear_in & ~clear_prev;
   assign accept     = (state == S_DEBOUNCE) && (keys == cap_keys) && (cnt == DB_LIMIT);
   assign full       = (ndigits == 4'd8);
   assign multi      = (state == S_IDLE) && (key_count > 5'd1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         cap_keys   <= '0;
         cap_code   <= '0;
         clear_prev <= 1'b0;
         key_valid  <= 1'b0;
         key_val    <= '0;
         clear_out  <= 1'b0;
         ndigits    <= '0;
         overflow   <= 1'b0;
      end else begin
         clear_prev <= clear_in;
         clear_out  <= clear_edge;
         key_valid  <= 1'b0;
         overflow   <= 1'b0;

         // A clear edge always wins over a key acceptance on the same edge; the key is lost.
         if (clear_edge) begin
            ndigits <= '0;
         end else if (accept) begin
            if (full) begin
               overflow <= 1'b1;
            end else begin
               key_valid <= 1'b1;
               key_val   <= cap_code;
               ndigits   <= ndigits + 4'd1;
            end
         end

         case (state)
            S_IDLE: begin
               if (key_count == 5'd1) begin
                  cap_keys <= keys;
                  cap_code <= key_code;
                  cnt      <= CW'(1);
                  state    <= S_DEBOUNCE;
               end
            end
            S_DEBOUNCE: begin
               if (keys != cap_keys) begin
                  state <= S_IDLE;
               end else if (cnt < DB_LIMIT) begin
                  cnt <= cnt + CW'(1);
               end else begin
                  state <= S_HELD;
               end
            end
            S_HELD: begin
               if (keys == 16'd0) begin
                  cnt   <= CW'(1);
                  state <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (keys != 16'd0) begin
                  cnt <= '0;
               end else if (cnt < DB_LIMIT) begin
                  cnt <= cnt + CW'(1);
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_ctrl.sv
// Directed bench for keypad_ctrl: expected strobes, overflows and clear pulses are queued
// with their cycle numbers when stimulus is driven and matched by a monitor on the falling edge.
module tb_keypad_ctrl;

   logic        clock;
   logic        reset;
   logic [15:0] keys;
   logic        clear_in;
   logic        key_valid;
   logic [3:0]  key_val;
   logic        clear_out;
   logic [3:0]  ndigits;
   logic        full;
   logic        overflow;
   logic        multi;

   typedef struct {
      logic [3:0] code;
      int         cyc;
   } exp_key_t;

   exp_key_t kq[$];
   int       oq[$];
   int       cq[$];
   int       cyc = 0;
   int       errors = 0;
   int       checks = 0;

   keypad_ctrl #(.DEBOUNCE(4), .CW(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .keys      (keys),
      .clear_in  (clear_in),
      .key_valid (key_valid),
      .key_val   (key_val),
      .clear_out (clear_out),
      .ndigits   (ndigits),
      .full      (full),
      .overflow  (overflow),
      .multi     (multi)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Monitor: every strobe, overflow and clear pulse must match the head of its queue.
   always @(negedge clock) begin
      exp_key_t e;
      int       x;
      if (key_valid || overflow)
         chk("valid_ovf_exclusive", {31'd0, key_valid & overflow}, 32'd0);
      if (key_valid) begin
         chk("unexpected_strobe", {31'd0, key_valid}, {31'd0, kq.size() != 0});
         if (kq.size() != 0) begin
            e = kq.pop_front();
            chk("strobe_code", {28'd0, key_val}, {28'd0, e.code});
            chk("strobe_cycle", cyc, e.cyc);
         end
      end
      if (overflow) begin
         chk("unexpected_overflow", {31'd0, overflow}, {31'd0, oq.size() != 0});
         if (oq.size() != 0) begin
            x = oq.pop_front();
            chk("overflow_cycle", cyc, x);
         end
      end
      if (clear_out) begin
         chk("unexpected_clear", {31'd0, clear_out}, {31'd0, cq.size() != 0});
         if (cq.size() != 0) begin
            x = cq.pop_front();
            chk("clear_cycle", cyc, x);
         end
      end
   end

   initial begin
      int c;
      reset    = 1'b0;
      keys     = 16'd0;
      clear_in = 1'b0;
      tick(3);
      chk("rst_key_valid", {31'd0, key_valid}, 32'd0);
      chk("rst_key_val", {28'd0, key_val}, 32'd0);
      chk("rst_clear_out", {31'd0, clear_out}, 32'd0);
      chk("rst_ndigits", {28'd0, ndigits}, 32'd0);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_multi", {31'd0, multi}, 32'd0);
      reset = 1'b1;
      tick(2);

      // Single key 5, with a chord added while held: one strobe only.
      c = cyc;
      keys = 16'h0020;
      kq.push_back('{4'h5, c + 5});
      tick(6);
      chk("t1_ndigits", {28'd0, ndigits}, 32'd1);
      chk("t1_key_val_hold", {28'd0, key_val}, 32'h5);
      keys = 16'h0021;
      #1;
      chk("t1_multi_in_held", {31'd0, multi}, 32'd0);
      tick(4);
      keys = 16'd0;
      tick(8);

      // Short bounce: no strobe.
      keys = 16'h0001;
      tick(2);
      keys = 16'd0;
      tick(7);
      chk("t2_ndigits", {28'd0, ndigits}, 32'd1);

      // Chord rejected, then the remaining single key accepted.
      keys = 16'h0011;
      #1;
      chk("t3_multi_now", {31'd0, multi}, 32'd1);
      tick(10);
      chk("t3_multi_held", {31'd0, multi}, 32'd1);
      c = cyc;
      keys = 16'h0010;
      kq.push_back('{4'h4, c + 5});
      tick(6);
      keys = 16'd0;
      tick(8);
      chk("t3_ndigits", {28'd0, ndigits}, 32'd2);
      chk("t3_key_val", {28'd0, key_val}, 32'h4);

      // Clear pulse empties the buffer.
      c = cyc;
      clear_in = 1'b1;
      cq.push_back(c + 1);
      tick(3);
      clear_in = 1'b0;
      tick(2);
      chk("clr_ndigits", {28'd0, ndigits}, 32'd0);

      // Nine presses: eight strobes, then an overflow.
      for (int k = 1; k <= 9; k++) begin
         c = cyc;
         keys = 16'd1 << k;
         if (k <= 8) kq.push_back('{4'(k), c + 5});
         else        oq.push_back(c + 5);
         tick(8);
         keys = 16'd0;
         tick(8);
         chk("t4_ndigits", {28'd0, ndigits}, (k > 8) ? 32'd8 : 32'(k));
      end
      chk("t4_full", {31'd0, full}, 32'd1);
      chk("t4_key_val", {28'd0, key_val}, 32'h8);

      // Clear edge coincides with acceptance: clear wins, key lost, no overflow.
      c = cyc;
      keys = 16'h0400;
      tick(4);
      clear_in = 1'b1;
      cq.push_back(c + 5);
      tick(2);
      chk("t5_ndigits", {28'd0, ndigits}, 32'd0);
      chk("t5_full", {31'd0, full}, 32'd0);
      tick(18);
      clear_in = 1'b0;
      keys = 16'd0;
      tick(8);
      chk("t5_key_val_kept", {28'd0, key_val}, 32'h8);
      chk("t5_ndigits_after", {28'd0, ndigits}, 32'd0);

      // Reset mid-debounce, key still held afterwards is a new press.
      keys = 16'h0080;
      tick(3);
      reset = 1'b0;
      #1;
      chk("t6_key_valid", {31'd0, key_valid}, 32'd0);
      chk("t6_key_val", {28'd0, key_val}, 32'd0);
      chk("t6_ndigits", {28'd0, ndigits}, 32'd0);
      chk("t6_full", {31'd0, full}, 32'd0);
      chk("t6_overflow", {31'd0, overflow}, 32'd0);
      chk("t6_clear_out", {31'd0, clear_out}, 32'd0);
      chk("t6_multi", {31'd0, multi}, 32'd0);
      tick(2);
      reset = 1'b1;
      c = cyc;
      kq.push_back('{4'h7, c + 5});
      tick(8);
      keys = 16'd0;
      tick(8);
      chk("t6_ndigits_after", {28'd0, ndigits}, 32'd1);
      chk("t6_key_val_after", {28'd0, key_val}, 32'h7);

      tick(4);
      chk("left_strobes", kq.size(), 32'd0);
      chk("left_overflows", oq.size(), 32'd0);
      chk("left_clears", cq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
